gpu_draw_sequencer: RTL and testbench
=====================================

Name: gpu_draw_sequencer

Overview:
Command sequencer that sits between the CPU-side bus registers and the SDRAM/HDMI line-write engine. It queues rectangle-fill and buffer-swap commands in a small FIFO. Each FILL is broken into one engine line write per row, using the engine's enable/busy handshake. Each SWAP toggles the ping-pong display buffer at a frame boundary, so software no longer polls busy per line.

Parameters:
FIFO_DEPTH, 8, command FIFO entries; power of 2, minimum 2
TIMEOUT_CYCLES, 65535, maximum cycles spent waiting for any single eng_busy edge before aborting

Ports:
clk  in  1  system clock
rstn  in  1  synchronous active-low reset
cmd_valid  in  1  command push request
cmd_ready  out  1  FIFO not full
cmd_op  in  2  0=NOP, 1=FILL, 2=SWAP, 3=reserved (treated as NOP)
cmd_x  in  16  FILL left x
cmd_y  in  16  FILL top y
cmd_w  in  16  FILL width in pixels
cmd_h  in  16  FILL height in rows
cmd_color  in  24  FILL RGB888 colour
eng_x_pos  out  16  to engine x_pos
eng_y_pos  out  16  to engine y_pos
eng_pixel  out  24  to engine pixel
eng_len  out  24  to engine len, zero-extended width
eng_enable  out  1  engine start, level
eng_busy  in  1  engine busy
frame_sync  in  1  one-cycle frame-boundary pulse from display timing
ping_pong  out  1  display buffer select
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries queued
idle  out  1  FIFO empty and FSM in IDLE
timeout_err  out  1  sticky abort flag
err_clr  in  1  clears timeout_err

Behaviour:
- Reset (rstn=0 at posedge clk): all eng_* outputs 0, ping_pong 0, timeout_err 0, FIFO emptied, fifo_level 0, FSM in IDLE. cmd_ready is 0 while rstn=0. Mid-operation reset drops eng_enable on that edge; the in-flight command is discarded.
- FIFO: a push occurs when cmd_valid and cmd_ready. cmd_ready = !full. There is no bypass; a push into a full FIFO is ignored. Push and pop in the same cycle leaves the level unchanged. The 90-bit entry is {op, x, y, w, h, color}.
- FSM states: IDLE, FETCH, ISSUE, DROP, SWAP_WAIT.
- IDLE: if the FIFO is not empty, pop the head into working registers and go to FETCH.
- FETCH:
  - FILL with w==0 or h==0: back to IDLE with no engine access.
  - FILL otherwise: load eng_x_pos=x, eng_y_pos=y, eng_pixel=color, eng_len={8'b0,w}, row_cnt=0, then go to ISSUE.
  - SWAP: go to SWAP_WAIT.
  - NOP or reserved: go to IDLE.
- ISSUE: eng_enable=1. When eng_busy=1 is sampled, go to DROP with eng_enable=0 on the same edge.
- DROP: wait for eng_busy=0. Then:
  - if row_cnt+1==h, go to IDLE;
  - else row_cnt+=1, eng_y_pos+=1, go to ISSUE.
- Row y arithmetic is 16-bit modulo (0xFFFF+1 wraps to 0). row_cnt is 16 bits.
- Latency: a push accepted at edge E0 into an empty FIFO with the FSM in IDLE gives FETCH after E1, and eng_enable=1 after E2. Between rows, eng_enable is low for at least 1 cycle after busy falls.
- Timeout: a counter clears on entry to ISSUE and to DROP and increments each cycle in those states. When it reaches TIMEOUT_CYCLES:
  - set timeout_err, force eng_enable=0, abandon the remaining rows, go to IDLE;
  - queued commands continue to execute.
- SWAP_WAIT: toggle ping_pong when eng_busy==0 and frame_sync==1 in the same cycle, then go to IDLE. frame_sync in any other state is ignored, and there is no timeout in SWAP_WAIT.
- err_clr clears timeout_err. If a set and err_clr occur in the same cycle, set wins.
- idle = (state==IDLE) && empty, registered consistently with state.
- eng_x_pos, eng_pixel and eng_len hold their values after a command completes until the next FILL loads.

Decomposition:
- Package gpu_seq_pkg: op codes (OP_NOP, OP_FILL, OP_SWAP), FSM state encoding, field widths (COORD_W=16, COLOR_W=24, LEN_W=24), entry width 90.
- Sub-module gpu_cmd_fifo: synchronous FIFO with parameterised depth and width, push/pop/full/empty/level, synchronous active-low reset.
- The FSM, row counter and timeout counter stay in gpu_draw_sequencer.

Test Plan:
- Push FILL x=10 y=20 w=100 h=3 color=0xFF0000; engine model raises busy 2 cycles after enable and holds it 5 cycles -> three handshakes with eng_y_pos 20, 21, 22, eng_len=100, eng_pixel=0xFF0000, then idle=1.
- Push FILL h=0 and FILL w=0, then FILL h=1 -> first two cause no eng_enable pulse; exactly one handshake follows.
- Push 8 FILLs with busy stuck high (FIFO_DEPTH=8) -> 9th push sees cmd_ready=0 while fifo_level=8. Release busy -> all 8 complete in order.
- FILL y=0xFFFE h=3 -> eng_y_pos sequence 0xFFFE, 0xFFFF, 0x0000.
- SWAP with busy low, frame_sync pulsing every 50 cycles -> ping_pong toggles exactly on the first pulse after SWAP_WAIT is entered. Same test with busy high during that pulse -> no toggle until the next pulse with busy low.
- TIMEOUT_CYCLES=16, busy never rises -> timeout_err=1 after 16 ISSUE cycles, eng_enable=0, next queued command issues. err_clr pulse clears the flag. Assert rstn=0 mid-FILL -> eng_enable=0 and fifo_level=0 on the next edge.

Source files
------------

// File: rtl/gpu_seq_pkg.sv
// Shared definitions for the draw sequencer: op codes, FSM states, field
// widths and the packed layout of one queued command.
package gpu_seq_pkg;

    localparam int OP_W    = 2;
    localparam int COORD_W = 16;
    localparam int COLOR_W = 24;
    localparam int LEN_W   = 24;
    localparam int ENTRY_W = 90;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_FILL = 2'd1,
        OP_SWAP = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_DROP      = 3'd3,
        ST_SWAP_WAIT = 3'd4
    } state_e;

    // Field order matches the FIFO entry {op, x, y, w, h, color}.
    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
        logic [COLOR_W-1:0] color;
    } cmd_t;

    // A FILL with no width or no height never touches the engine.
    function automatic logic fill_is_empty(input cmd_t c);
        return (c.w == 16'd0) || (c.h == 16'd0);
    endfunction

endpackage

// File: rtl/gpu_draw_sequencer_fifo.sv
// Synchronous command FIFO with occupancy count. Pushes while full and pops
// while empty are ignored; storage is left unreset so it can map to RAM.
module gpu_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 90
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_level == (AW+1)'(DEPTH));
    assign empty     = (r_level == {(AW+1){1'b0}});
    assign level     = r_level;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage write port.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and level; simultaneous push and pop leaves the level alone.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_level  <= {(AW+1){1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/gpu_draw_sequencer.sv
// Draw command sequencer: queues FILL/SWAP commands, splits each FILL into
// per-row engine writes over the enable/busy handshake, and flips the display
// buffer on a frame boundary for SWAP.
module gpu_draw_sequencer
    import gpu_seq_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [15:0]                   cmd_x,
    input  logic [15:0]                   cmd_y,
    input  logic [15:0]                   cmd_w,
    input  logic [15:0]                   cmd_h,
    input  logic [23:0]                   cmd_color,
    output logic [15:0]                   eng_x_pos,
    output logic [15:0]                   eng_y_pos,
    output logic [23:0]                   eng_pixel,
    output logic [23:0]                   eng_len,
    output logic                          eng_enable,
    input  logic                          eng_busy,
    input  logic                          frame_sync,
    output logic                          ping_pong,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          idle,
    output logic                          timeout_err,
    input  logic                          err_clr
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_e              r_state;
    cmd_t                r_cmd;
    logic [15:0]         r_row_cnt;
    logic [TMO_W-1:0]    r_tmo;
    logic [15:0]         r_eng_x_pos;
    logic [15:0]         r_eng_y_pos;
    logic [23:0]         r_eng_pixel;
    logic [23:0]         r_eng_len;
    logic                r_eng_enable;
    logic                r_ping_pong;
    logic                r_timeout_err;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [ENTRY_W-1:0]  w_head;
    logic                w_tmo_hit;

    assign cmd_ready = rstn && !w_full;
    assign w_push    = cmd_valid && cmd_ready;
    assign w_pop     = (r_state == ST_IDLE) && !w_empty;

    // Timeout fires on the cycle the counter reaches its limit while still
    // waiting for the busy edge the current state is looking for.
    assign w_tmo_hit = (r_tmo == TMO_LAST) &&
                       (((r_state == ST_ISSUE) && !eng_busy) ||
                        ((r_state == ST_DROP)  &&  eng_busy));

    gpu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color}),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

    // Main FSM: fetch, per-row engine handshake, swap wait, timeout abort.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_cmd        <= '0;
            r_row_cnt    <= 16'd0;
            r_tmo        <= {TMO_W{1'b0}};
            r_eng_x_pos  <= 16'd0;
            r_eng_y_pos  <= 16'd0;
            r_eng_pixel  <= 24'd0;
            r_eng_len    <= 24'd0;
            r_eng_enable <= 1'b0;
            r_ping_pong  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_cmd   <= cmd_t'(w_head);
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    case (r_cmd.op)
                        OP_FILL: begin
                            if (fill_is_empty(r_cmd)) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_eng_x_pos  <= r_cmd.x;
                                r_eng_y_pos  <= r_cmd.y;
                                r_eng_pixel  <= r_cmd.color;
                                r_eng_len    <= {8'd0, r_cmd.w};
                                r_row_cnt    <= 16'd0;
                                r_tmo        <= {TMO_W{1'b0}};
                                r_eng_enable <= 1'b1;
                                r_state      <= ST_ISSUE;
                            end
                        end
                        OP_SWAP: r_state <= ST_SWAP_WAIT;
                        default: r_state <= ST_IDLE;
                    endcase
                end
                ST_ISSUE: begin
                    if (eng_busy) begin
                        r_eng_enable <= 1'b0;
                        r_tmo        <= {TMO_W{1'b0}};
                        r_state      <= ST_DROP;
                    end else if (w_tmo_hit) begin
                        r_eng_enable <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                ST_DROP: begin
                    if (!eng_busy) begin
                        if ((r_row_cnt + 16'd1) == r_cmd.h) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_row_cnt    <= r_row_cnt + 16'd1;
                            r_eng_y_pos  <= r_eng_y_pos + 16'd1;
                            r_tmo        <= {TMO_W{1'b0}};
                            r_eng_enable <= 1'b1;
                            r_state      <= ST_ISSUE;
                        end
                    end else if (w_tmo_hit) begin
                        r_eng_enable <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                ST_SWAP_WAIT: begin
                    if (!eng_busy && frame_sync) begin
                        r_ping_pong <= !r_ping_pong;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_eng_enable <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky abort flag; a new timeout outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_timeout_err <= 1'b0;
        end else if (w_tmo_hit) begin
            r_timeout_err <= 1'b1;
        end else if (err_clr) begin
            r_timeout_err <= 1'b0;
        end
    end

    assign eng_x_pos   = r_eng_x_pos;
    assign eng_y_pos   = r_eng_y_pos;
    assign eng_pixel   = r_eng_pixel;
    assign eng_len     = r_eng_len;
    assign eng_enable  = r_eng_enable;
    assign ping_pong   = r_ping_pong;
    assign timeout_err = r_timeout_err;
    assign idle        = (r_state == ST_IDLE) && w_empty;

endmodule

// File: tb/tb_gpu_draw_sequencer.sv
// Self-checking bench for gpu_draw_sequencer: directed scenarios plus a
// randomized command stream, checked against a row-level handshake model.
module tb_gpu_draw_sequencer;

    localparam int DEPTH = 8;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_x, cmd_y, cmd_w, cmd_h;
    logic [23:0] cmd_color;
    logic [15:0] eng_x_pos, eng_y_pos;
    logic [23:0] eng_pixel, eng_len;
    logic        eng_enable;
    logic        eng_busy;
    logic        frame_sync;
    logic        ping_pong;
    logic [3:0]  fifo_level;
    logic        idle;
    logic        timeout_err;
    logic        err_clr;

    always #5 clk = ~clk;

    gpu_draw_sequencer #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_x       (cmd_x),
        .cmd_y       (cmd_y),
        .cmd_w       (cmd_w),
        .cmd_h       (cmd_h),
        .cmd_color   (cmd_color),
        .eng_x_pos   (eng_x_pos),
        .eng_y_pos   (eng_y_pos),
        .eng_pixel   (eng_pixel),
        .eng_len     (eng_len),
        .eng_enable  (eng_enable),
        .eng_busy    (eng_busy),
        .frame_sync  (frame_sync),
        .ping_pong   (ping_pong),
        .fifo_level  (fifo_level),
        .idle        (idle),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int hs_count = 0;
    int eng_mode = 1;       // 0 = normal responder, 1 = busy held low, 2 = busy held high
    int dly_fix  = 0;       // nonzero: fixed enable-to-busy delay
    int hold_fix = 0;       // nonzero: fixed busy duration
    logic [79:0] exp_hs[$]; // expected {x, y, len, pixel} per row, in order
    logic exp_pp = 1'b0;

    task automatic chk_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: a FILL produces one engine write per row, y wrapping mod 2^16.
    task automatic model_fill(input logic [15:0] x, input logic [15:0] y, input logic [15:0] w,
                              input logic [15:0] h, input logic [23:0] c, input int max_rows);
        int n;
        logic [15:0] yy;
        n = (w == 16'd0 || h == 16'd0) ? 0 : int'(h);
        if (max_rows >= 0 && max_rows < n) n = max_rows;
        for (int i = 0; i < n; i++) begin
            yy = y + 16'(i);
            exp_hs.push_back({x, yy, {8'd0, w}, c});
        end
    endtask

    task automatic push_cmd(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] w, input logic [15:0] h, input logic [23:0] c,
                            input int max_rows, output bit accepted);
        @(negedge clk);
        cmd_op = op; cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = c;
        cmd_valid = 1'b1;
        accepted = cmd_ready;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        if (accepted && op == 2'd1) model_fill(x, y, w, h, c, max_rows);
    endtask

    task automatic wait_en(input string tag, input int budget);
        int n = 0;
        while (!eng_enable && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk_eq(tag, 80'(eng_enable), 80'd1);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (!(idle && exp_hs.size() == 0 && !eng_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk_eq(tag, 80'(idle && (exp_hs.size() == 0)), 80'd1);
    endtask

    // One frame period of 50 cycles ending in a single-cycle frame_sync pulse.
    task automatic frame_period();
        repeat (49) @(negedge clk);
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
    endtask

    // Engine responder: busy rises some cycles after enable and holds a while.
    initial begin
        int d, hh;
        eng_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (eng_mode == 2) eng_busy = 1'b1;
            else if (eng_mode == 1) eng_busy = 1'b0;
            else if (eng_busy) eng_busy = 1'b0;
            else if (eng_enable) begin
                d  = (dly_fix  != 0) ? dly_fix  : int'($urandom_range(1, 3));
                hh = (hold_fix != 0) ? hold_fix : int'($urandom_range(1, 5));
                repeat (d) @(posedge clk);
                #1 eng_busy = 1'b1;
                repeat (hh) @(posedge clk);
                #1 eng_busy = 1'b0;
            end
        end
    end

    // Handshake monitor: each rising eng_enable must match the next model row.
    initial begin
        logic prev_en;
        logic [79:0] e;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn && eng_enable && !prev_en) begin
                hs_count++;
                if (exp_hs.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL hs_extra: got handshake y=0x%0h expected none", eng_y_pos);
                end else begin
                    e = exp_hs.pop_front();
                    chk_eq("hs_fields", {eng_x_pos, eng_y_pos, eng_len, eng_pixel}, e);
                end
            end
            prev_en = eng_enable;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        int hs0, nacc;
        int r;
        logic [1:0] op;
        logic [15:0] rw;
        rstn = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_x = 16'd0; cmd_y = 16'd0;
        cmd_w = 16'd0; cmd_h = 16'd0; cmd_color = 24'd0; frame_sync = 1'b0; err_clr = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_eq("rst_ready", 80'(cmd_ready), 80'd0);
        chk_eq("rst_eng", {eng_x_pos, eng_y_pos, eng_len, eng_pixel}, 80'd0);
        chk_eq("rst_misc", {eng_enable, ping_pong, timeout_err, fifo_level}, 80'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk_eq("post_rst_idle", {idle, cmd_ready}, 80'b11);

        // Basic 3-row FILL with fixed engine timing, plus first-command latency
        eng_mode = 0; dly_fix = 2; hold_fix = 5;
        hs0 = hs_count;
        push_cmd(2'd1, 16'd10, 16'd20, 16'd100, 16'd3, 24'hFF0000, -1, acc);
        @(negedge clk);
        chk_eq("lat_level", {idle, fifo_level}, 80'h01);
        @(negedge clk);
        chk_eq("lat_e1", 80'(eng_enable), 80'd0);
        @(negedge clk);
        chk_eq("lat_e2", 80'(eng_enable), 80'd1);
        wait_drain("fill3_drain", 400);
        chk_eq("fill3_rows", 80'(hs_count - hs0), 80'd3);
        chk_eq("fill3_hold", {eng_x_pos, eng_len, eng_pixel}, {16'd10, 24'd100, 24'hFF0000});

        // Degenerate FILLs produce no engine access
        dly_fix = 0; hold_fix = 0;
        hs0 = hs_count;
        push_cmd(2'd1, 16'd1, 16'd2, 16'd5, 16'd0, 24'h123456, -1, acc);
        push_cmd(2'd1, 16'd1, 16'd2, 16'd0, 16'd4, 24'h123456, -1, acc);
        push_cmd(2'd1, 16'd3, 16'd4, 16'd7, 16'd1, 24'hABCDEF, -1, acc);
        wait_drain("degen_drain", 400);
        chk_eq("degen_rows", 80'(hs_count - hs0), 80'd1);

        // Row y wraps at 16 bits
        hs0 = hs_count;
        push_cmd(2'd1, 16'h0040, 16'hFFFE, 16'd2, 16'd3, 24'h00FF00, -1, acc);
        wait_drain("wrap_drain", 400);
        chk_eq("wrap_rows", 80'(hs_count - hs0), 80'd3);

        // Fill the FIFO while the engine is stuck busy
        eng_mode = 2;
        @(negedge clk);
        push_cmd(2'd1, 16'd100, 16'd200, 16'd8, 16'd1, 24'h0000FF, -1, acc);
        wait_en("stuck_en", 10);
        nacc = 0;
        for (int i = 0; i < DEPTH; i++) begin
            push_cmd(2'd1, 16'(i), 16'(i * 3), 16'(i + 1), 16'd2, 24'(i * 17), -1, acc);
            nacc += int'(acc);
        end
        chk_eq("full_accepts", 80'(nacc), 80'(DEPTH));
        chk_eq("full_level", {cmd_ready, fifo_level}, {1'b0, 4'(DEPTH)});
        push_cmd(2'd1, 16'd999, 16'd999, 16'd9, 16'd9, 24'd9, -1, acc);
        chk_eq("push9_refused", 80'(acc), 80'd0);
        eng_mode = 0;
        wait_drain("full_drain", 2000);
        chk_eq("full_no_tmo", 80'(timeout_err), 80'd0);

        // SWAP: toggle only on a frame pulse with busy low while waiting
        eng_mode = 1;
        @(negedge clk);
        frame_period();
        chk_eq("pp_idle_pulse", 80'(ping_pong), 80'(exp_pp));
        push_cmd(2'd2, 16'd0, 16'd0, 16'd0, 16'd0, 24'd0, -1, acc);
        repeat (3) @(negedge clk);
        chk_eq("pp_wait", 80'(ping_pong), 80'(exp_pp));
        frame_period();
        exp_pp = ~exp_pp;
        chk_eq("pp_toggle", 80'(ping_pong), 80'(exp_pp));
        push_cmd(2'd2, 16'd0, 16'd0, 16'd0, 16'd0, 24'd0, -1, acc);
        repeat (3) @(negedge clk);
        eng_mode = 2;
        frame_period();
        chk_eq("pp_busy_hold", 80'(ping_pong), 80'(exp_pp));
        eng_mode = 1;
        frame_period();
        exp_pp = ~exp_pp;
        chk_eq("pp_toggle2", {idle, ping_pong}, {1'b1, exp_pp});

        // Timeout: busy never rises; first FILL abandoned after one row
        push_cmd(2'd1, 16'd5, 16'd6, 16'd9, 16'd2, 24'h111111, 1, acc);
        push_cmd(2'd1, 16'd7, 16'd8, 16'd10, 16'd1, 24'h222222, -1, acc);
        wait_en("tmo_en", 10);
        repeat (TMO - 1) @(negedge clk);
        chk_eq("tmo_before", {timeout_err, eng_enable}, 80'b01);
        @(negedge clk);
        chk_eq("tmo_hit", {timeout_err, eng_enable}, 80'b10);
        wait_en("tmo_next_en", 10);
        eng_mode = 0;
        wait_drain("tmo_drain", 400);
        chk_eq("tmo_sticky", 80'(timeout_err), 80'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk_eq("tmo_clear", 80'(timeout_err), 80'd0);

        // Randomized command stream
        eng_mode = 0;
        for (int k = 0; k < 40; k++) begin
            r  = int'($urandom_range(0, 7));
            op = (r < 6) ? 2'd1 : ((r == 6) ? 2'd0 : 2'd3);
            rw = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
            push_cmd(op, 16'($urandom), 16'($urandom), rw, 16'($urandom_range(0, 4)),
                     24'($urandom), -1, acc);
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        wait_drain("rand_drain", 10000);
        chk_eq("rand_no_tmo", 80'(timeout_err), 80'd0);

        // Reset in the middle of a FILL
        push_cmd(2'd1, 16'd50, 16'd60, 16'd70, 16'd4, 24'h333333, -1, acc);
        push_cmd(2'd1, 16'd51, 16'd61, 16'd71, 16'd2, 24'h444444, -1, acc);
        wait_en("mid_en", 10);
        rstn = 1'b0;
        @(negedge clk);
        chk_eq("mid_rst", {eng_enable, cmd_ready, ping_pong, fifo_level}, 80'd0);
        exp_hs.delete();
        exp_pp = 1'b0;
        rstn = 1'b1;
        repeat (15) @(negedge clk);
        chk_eq("mid_rst_idle", {idle, eng_enable, fifo_level}, {1'b1, 1'b0, 4'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
